// File: rtl/pc_redirect_if.sv
// EXE/IF-side signal bundle for the PC redirect unit.
// The master side drives the EXE/IF inputs. The slave side is the redirect controller.
interface pc_redirect_if #(
  parameter int XLEN = 32
);
  logic            ex_valid;
  logic [6:0]      opcode_ex;
  logic            branch_taken;
  logic [XLEN-1:0] pc_jump;
  logic [XLEN-1:0] alu_result;
  logic            fetch_ready;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            flush_if_id;
  logic            flush_id_ex;
  logic            misalign_exc;
  logic [XLEN-1:0] misalign_addr;
  logic            busy;

  modport master (
    output ex_valid, opcode_ex, branch_taken, pc_jump, alu_result, fetch_ready,
    input  redirect_valid, redirect_pc, flush_if_id, flush_id_ex,
           misalign_exc, misalign_addr, busy
  );

  modport slave (
    input  ex_valid, opcode_ex, branch_taken, pc_jump, alu_result, fetch_ready,
    output redirect_valid, redirect_pc, flush_if_id, flush_id_ex,
           misalign_exc, misalign_addr, busy
  );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// EXE/IF control-flow redirect unit: selects and aligns the jump/branch target,
// holds it until fetch accepts it, then squashes IF/ID work for FLUSH_CYCLES cycles.
module pc_redirect_ctrl #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int IALIGN       = 32
) (
  input logic          clk,
  input logic          rst,
  pc_redirect_if.slave bus
);
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, PENDING, FLUSH} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
  logic              flush_if_id_q, flush_if_id_d;
  logic              flush_id_ex_q, flush_id_ex_d;
  logic              misalign_exc_q, misalign_exc_d;
  logic [XLEN-1:0]   misalign_addr_q, misalign_addr_d;

  logic              is_jalr;
  logic              req;
  logic              misaligned;
  logic [XLEN-1:0]   target_raw;
  logic [XLEN-1:0]   target;

  always_comb begin
    is_jalr    = (bus.opcode_ex == OP_JALR);
    req        = bus.ex_valid & ((bus.opcode_ex == OP_JAL) | is_jalr |
                                 ((bus.opcode_ex == OP_BRANCH) & bus.branch_taken));
    target_raw = is_jalr ? bus.alu_result : bus.pc_jump;
    target     = {target_raw[XLEN-1:1], target_raw[0] & ~is_jalr};
    // With 16-bit alignment bit 0 is already clear for every source, so nothing can trap.
    misaligned = (IALIGN == 32) ? target[1] : 1'b0;
  end

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    redirect_valid_d = redirect_valid_q;
    redirect_pc_d    = redirect_pc_q;
    flush_if_id_d    = flush_if_id_q;
    flush_id_ex_d    = 1'b0;
    misalign_exc_d   = 1'b0;
    misalign_addr_d  = misalign_addr_q;
    case (state_q)
      IDLE: begin
        redirect_valid_d = 1'b0;
        flush_if_id_d    = 1'b0;
        if (req) begin
          if (misaligned) begin
            misalign_exc_d  = 1'b1;
            misalign_addr_d = target;
          end else begin
            state_d          = PENDING;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = target;
            flush_if_id_d    = 1'b1;
            flush_id_ex_d    = 1'b1;
          end
        end
      end
      PENDING: begin
        if (bus.fetch_ready) begin
          redirect_valid_d = 1'b0;
          flush_if_id_d    = 1'b1;
          // A single flush cycle is covered by the registered flush in the first IDLE cycle.
          if (FLUSH_CYCLES == 1) begin
            state_d = IDLE;
          end else begin
            state_d = FLUSH;
            cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
          end
        end
      end
      FLUSH: begin
        if (cnt_q == '0) begin
          state_d       = IDLE;
          flush_if_id_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      flush_if_id_q    <= 1'b0;
      flush_id_ex_q    <= 1'b0;
      misalign_exc_q   <= 1'b0;
      misalign_addr_q  <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      flush_if_id_q    <= flush_if_id_d;
      flush_id_ex_q    <= flush_id_ex_d;
      misalign_exc_q   <= misalign_exc_d;
      misalign_addr_q  <= misalign_addr_d;
    end
  end

  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.flush_if_id    = flush_if_id_q;
  assign bus.flush_id_ex    = flush_id_ex_q;
  assign bus.misalign_exc   = misalign_exc_q;
  assign bus.misalign_addr  = misalign_addr_q;
  assign bus.busy           = (state_q != IDLE);
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl: one instance with FLUSH_CYCLES=2 and one with FLUSH_CYCLES=1.
module tb_pc_redirect_ctrl;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  pc_redirect_if #(.XLEN(32)) ifa ();
  pc_redirect_if #(.XLEN(32)) ifb ();

  pc_redirect_ctrl #(.XLEN(32), .FLUSH_CYCLES(2), .IALIGN(32)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  pc_redirect_ctrl #(.XLEN(32), .FLUSH_CYCLES(1), .IALIGN(32)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive_a(input logic ev, input logic [6:0] op, input logic bt,
                         input logic [31:0] pj, input logic [31:0] alu, input logic fr);
    ifa.ex_valid     = ev;
    ifa.opcode_ex    = op;
    ifa.branch_taken = bt;
    ifa.pc_jump      = pj;
    ifa.alu_result   = alu;
    ifa.fetch_ready  = fr;
  endtask

  task automatic chk_a(input string tag, input logic rv, input logic [31:0] pc,
                       input logic fif, input logic fie, input logic bsy);
    chk({tag, ".redirect_valid"}, {31'b0, ifa.redirect_valid}, {31'b0, rv});
    chk({tag, ".redirect_pc"},    ifa.redirect_pc, pc);
    chk({tag, ".flush_if_id"},    {31'b0, ifa.flush_if_id}, {31'b0, fif});
    chk({tag, ".flush_id_ex"},    {31'b0, ifa.flush_id_ex}, {31'b0, fie});
    chk({tag, ".busy"},           {31'b0, ifa.busy}, {31'b0, bsy});
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    drive_a(1'b0, 7'd0, 1'b0, 32'h0, 32'h0, 1'b1);
    ifb.ex_valid     = 1'b0;
    ifb.opcode_ex    = 7'd0;
    ifb.branch_taken = 1'b0;
    ifb.pc_jump      = 32'h0;
    ifb.alu_result   = 32'h0;
    ifb.fetch_ready  = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk_a("reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("reset.misalign_exc", {31'b0, ifa.misalign_exc}, 32'h0);
    chk("reset.misalign_addr", ifa.misalign_addr, 32'h0);
    chk("reset_b.busy", {31'b0, ifb.busy}, 32'h0);

    // JAL with fetch ready: 1 pending cycle, then 2 flush cycles
    drive_a(1'b1, OP_JAL, 1'b0, 32'h100, 32'h0, 1'b1);
    tick();
    drive_a(1'b0, OP_JAL, 1'b0, 32'h100, 32'h0, 1'b1);
    chk_a("jal.c1", 1'b1, 32'h100, 1'b1, 1'b1, 1'b1);
    tick();
    chk_a("jal.c2", 1'b0, 32'h100, 1'b1, 1'b0, 1'b1);
    tick();
    chk_a("jal.c3", 1'b0, 32'h100, 1'b1, 1'b0, 1'b1);
    tick();
    chk_a("jal.c4", 1'b0, 32'h100, 1'b0, 1'b0, 1'b0);

    // JALR target has bit 0 cleared
    drive_a(1'b1, OP_JALR, 1'b0, 32'h0, 32'h205, 1'b1);
    tick();
    drive_a(1'b0, OP_JALR, 1'b0, 32'h0, 32'h205, 1'b1);
    chk_a("jalr.c1", 1'b1, 32'h204, 1'b1, 1'b1, 1'b1);
    tick();
    tick();
    tick();
    chk_a("jalr.idle", 1'b0, 32'h204, 1'b0, 1'b0, 1'b0);

    // JALR misaligned target raises the exception and no redirect
    drive_a(1'b1, OP_JALR, 1'b0, 32'h0, 32'h206, 1'b1);
    tick();
    drive_a(1'b0, OP_JALR, 1'b0, 32'h0, 32'h0, 1'b1);
    chk("mis.exc", {31'b0, ifa.misalign_exc}, 32'h1);
    chk("mis.addr", ifa.misalign_addr, 32'h206);
    chk_a("mis.c1", 1'b0, 32'h204, 1'b0, 1'b0, 1'b0);
    tick();
    chk("mis.exc_pulse", {31'b0, ifa.misalign_exc}, 32'h0);
    chk("mis.addr_held", ifa.misalign_addr, 32'h206);

    // Misaligned JAL target
    drive_a(1'b1, OP_JAL, 1'b0, 32'h102, 32'h0, 1'b1);
    tick();
    drive_a(1'b0, OP_JAL, 1'b0, 32'h0, 32'h0, 1'b1);
    chk("misjal.exc", {31'b0, ifa.misalign_exc}, 32'h1);
    chk("misjal.addr", ifa.misalign_addr, 32'h102);
    chk("misjal.rv", {31'b0, ifa.redirect_valid}, 32'h0);
    tick();

    // Not-taken branch does nothing
    drive_a(1'b1, OP_BRANCH, 1'b0, 32'h40, 32'h0, 1'b1);
    tick();
    chk_a("br_nt", 1'b0, 32'h204, 1'b0, 1'b0, 1'b0);
    chk("br_nt.exc", {31'b0, ifa.misalign_exc}, 32'h0);

    // Taken branch with fetch stalled 4 cycles; JAL requests in the wait are ignored
    drive_a(1'b1, OP_BRANCH, 1'b1, 32'h40, 32'h0, 1'b0);
    tick();
    drive_a(1'b1, OP_JAL, 1'b0, 32'h300, 32'h0, 1'b0);
    chk_a("br_t.c1", 1'b1, 32'h40, 1'b1, 1'b1, 1'b1);
    for (int i = 2; i <= 5; i++) begin
      tick();
      chk_a($sformatf("br_t.c%0d", i), 1'b1, 32'h40, 1'b1, 1'b0, 1'b1);
    end
    drive_a(1'b0, OP_JAL, 1'b0, 32'h300, 32'h0, 1'b1);
    tick();
    chk_a("br_t.c6", 1'b0, 32'h40, 1'b1, 1'b0, 1'b1);
    tick();
    chk_a("br_t.c7", 1'b0, 32'h40, 1'b1, 1'b0, 1'b1);
    tick();
    chk_a("br_t.c8", 1'b0, 32'h40, 1'b0, 1'b0, 1'b0);

    // Back-to-back: request in the first IDLE cycle after FLUSH
    drive_a(1'b1, OP_JAL, 1'b0, 32'h80, 32'h0, 1'b1);
    tick();
    drive_a(1'b0, OP_JAL, 1'b0, 32'h80, 32'h0, 1'b1);
    chk_a("b2b.c1", 1'b1, 32'h80, 1'b1, 1'b1, 1'b1);
    tick();
    tick();
    tick();
    chk_a("b2b.idle", 1'b0, 32'h80, 1'b0, 1'b0, 1'b0);

    // Reset in the second PENDING cycle drops the redirect
    drive_a(1'b1, OP_JAL, 1'b0, 32'h1c0, 32'h0, 1'b0);
    tick();
    drive_a(1'b0, OP_JAL, 1'b0, 32'h1c0, 32'h0, 1'b0);
    chk_a("rstp.c1", 1'b1, 32'h1c0, 1'b1, 1'b1, 1'b1);
    tick();
    chk_a("rstp.c2", 1'b1, 32'h1c0, 1'b1, 1'b0, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive_a(1'b0, OP_JAL, 1'b0, 32'h0, 32'h0, 1'b1);
    chk_a("rstp.after", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("rstp.addr", ifa.misalign_addr, 32'h0);

    // FLUSH_CYCLES=1 instance: IDLE right after the handshake
    ifb.ex_valid  = 1'b1;
    ifb.opcode_ex = OP_JAL;
    ifb.pc_jump   = 32'h500;
    tick();
    ifb.ex_valid  = 1'b0;
    chk("fc1.c1.rv", {31'b0, ifb.redirect_valid}, 32'h1);
    chk("fc1.c1.pc", ifb.redirect_pc, 32'h500);
    chk("fc1.c1.busy", {31'b0, ifb.busy}, 32'h1);
    tick();
    chk("fc1.c2.rv", {31'b0, ifb.redirect_valid}, 32'h0);
    chk("fc1.c2.busy", {31'b0, ifb.busy}, 32'h0);
    chk("fc1.c2.fif", {31'b0, ifb.flush_if_id}, 32'h1);
    tick();
    chk("fc1.c3.fif", {31'b0, ifb.flush_if_id}, 32'h0);
    chk("fc1.c3.busy", {31'b0, ifb.busy}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
